// File: rtl/chess_turn_ctrl.sv
// chess_turn_ctrl: chess timer game sequencer (optional move counter via MOVE_COUNT_EN)
module chess_turn_ctrl #(
  parameter int TIME_W = 6,
  parameter int MOVE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              new_game,
  input  logic              start_pause,
  input  logic              btn_a,
  input  logic              btn_b,
  input  logic [TIME_W-1:0] time_cfg,
  input  logic [TIME_W-1:0] min_a,
  input  logic [TIME_W-1:0] sec_a,
  input  logic [TIME_W-1:0] min_b,
  input  logic [TIME_W-1:0] sec_b,
  output logic              load,
  output logic [TIME_W-1:0] load_val,
  output logic              en_a,
  output logic              en_b,
  output logic              turn_a,
  output logic              turn_b,
  output logic              paused,
  output logic              flag_a,
`ifdef MOVE_COUNT_EN
  output logic [MOVE_W-1:0] moves,
`endif
  output logic              flag_b
);
  typedef enum logic [3:0] {
    IDLE, LOAD, READY, RUN_A, RUN_B, PAUSE_A, PAUSE_B, FLAG_A, FLAG_B
  } state_t;
  state_t r_state, w_next;
  logic [TIME_W-1:0] r_load_val;
  logic w_zero_a, w_zero_b;
  assign w_zero_a = (min_a == '0) && (sec_a == '0);
  assign w_zero_b = (min_b == '0) && (sec_b == '0);
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // start minutes captured on the new_game pulse; zero would flag instantly, so clamp to 1
  always_ff @(posedge clk or posedge rst)
    if (rst)           r_load_val <= TIME_W'(1);
    else if (new_game) r_load_val <= (time_cfg == '0) ? TIME_W'(1) : time_cfg;
  // next state: new_game overrides everything, then flag, pause, player button
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = IDLE;
      LOAD:    w_next = READY;
      READY:   w_next = (btn_b || start_pause) ? RUN_A : READY;
      RUN_A:   w_next = w_zero_a ? FLAG_A : start_pause ? PAUSE_A : btn_a ? RUN_B : RUN_A;
      RUN_B:   w_next = w_zero_b ? FLAG_B : start_pause ? PAUSE_B : btn_b ? RUN_A : RUN_B;
      PAUSE_A: w_next = start_pause ? RUN_A : PAUSE_A;
      PAUSE_B: w_next = start_pause ? RUN_B : PAUSE_B;
      FLAG_A:  w_next = FLAG_A;
      FLAG_B:  w_next = FLAG_B;
      default: w_next = IDLE;
    endcase
    if (new_game) w_next = LOAD;
  end
  // outputs decode the registered state; enables gate tick with no latency
  always_comb begin
    load     = r_state == LOAD;
    load_val = r_load_val;
    en_a     = (r_state == RUN_A) && tick;
    en_b     = (r_state == RUN_B) && tick;
    turn_a   = (r_state == RUN_A) || (r_state == PAUSE_A) || (r_state == FLAG_A);
    turn_b   = (r_state == RUN_B) || (r_state == PAUSE_B) || (r_state == FLAG_B);
    paused   = (r_state == PAUSE_A) || (r_state == PAUSE_B);
    flag_a   = r_state == FLAG_A;
    flag_b   = r_state == FLAG_B;
  end
`ifdef MOVE_COUNT_EN
  logic [MOVE_W-1:0] r_moves;
  // a full move completes when black's press hands the clock back to white
  always_ff @(posedge clk or posedge rst)
    if (rst)                                             r_moves <= '0;
    else if (r_state == LOAD)                            r_moves <= '0;
    else if (r_state == RUN_B && w_next == RUN_A && r_moves != '1) r_moves <= r_moves + 1'b1;
  assign moves = r_moves;
`endif
endmodule

// File: tb/tb_chess_turn_ctrl.sv
// tb_chess_turn_ctrl: scoreboard bench for the chess timer sequencer
module tb_chess_turn_ctrl;
  logic clk = 0, rst = 1, tick = 0, new_game = 0, start_pause = 0, btn_a = 0, btn_b = 0;
  logic [5:0] time_cfg = 0, min_a = 5, sec_a = 0, min_b = 5, sec_b = 0;
  logic load, en_a, en_b, turn_a, turn_b, paused, flag_a, flag_b;
  logic [5:0] load_val;
`ifdef MOVE_COUNT_EN
  logic [7:0] moves;
`endif
  int total = 0, bad = 0;
  typedef struct {string nm; logic [13:0] v; bit mc; logic [7:0] mv;} exp_t;
  exp_t q[$];

  chess_turn_ctrl #(.TIME_W(6), .MOVE_W(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .new_game(new_game), .start_pause(start_pause),
    .btn_a(btn_a), .btn_b(btn_b), .time_cfg(time_cfg), .min_a(min_a), .sec_a(sec_a),
    .min_b(min_b), .sec_b(sec_b), .load(load), .load_val(load_val), .en_a(en_a), .en_b(en_b),
    .turn_a(turn_a), .turn_b(turn_b), .paused(paused), .flag_a(flag_a),
`ifdef MOVE_COUNT_EN
    .moves(moves),
`endif
    .flag_b(flag_b));

  always #5 clk = ~clk;

  function automatic logic [13:0] ex(bit ld, logic [5:0] lv, bit ea, bit eb, bit ta, bit tb, bit p, bit fa, bit fb);
    return {ld, lv, ea, eb, ta, tb, p, fa, fb};
  endfunction
  function automatic logic [13:0] ra(logic [5:0] lv, bit t);
    return ex(0, lv, t, 0, 1, 0, 0, 0, 0);
  endfunction
  function automatic logic [13:0] rb(logic [5:0] lv, bit t);
    return ex(0, lv, 0, t, 0, 1, 0, 0, 0);
  endfunction
  function automatic logic [13:0] zz(logic [5:0] lv);
    return ex(0, lv, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic cycm(input string nm, input logic [13:0] v, input bit mc, input logic [7:0] mv);
    exp_t e;
    e.nm = nm; e.v = v; e.mc = mc; e.mv = mv;
    q.push_back(e);
    @(posedge clk); #1;
    tick = 0; new_game = 0; start_pause = 0; btn_a = 0; btn_b = 0;
  endtask
  task automatic cyc(input string nm, input logic [13:0] v);
    cycm(nm, v, 0, 0);
  endtask

  // monitor: compares the DUT against the oldest expectation mid-cycle
  always @(negedge clk) begin
    exp_t e;
    logic [13:0] got;
    if (q.size() != 0) begin
      e = q.pop_front();
      got = {load, load_val, en_a, en_b, turn_a, turn_b, paused, flag_a, flag_b};
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s: got=%b exp=%b", e.nm, got, e.v);
      end
`ifdef MOVE_COUNT_EN
      if (e.mc) begin
        total++;
        if (moves !== e.mv) begin
          bad++;
          $display("FAIL %s_moves: got=%0d exp=%0d", e.nm, moves, e.mv);
        end
      end
`endif
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    cyc("idle", zz(1));
    btn_b = 1; start_pause = 1; cyc("idle_ign", zz(1));
    time_cfg = 5; new_game = 1; cyc("ng", zz(1));
    cyc("load", ex(1, 5, 0, 0, 0, 0, 0, 0, 0));
    cyc("ready", zz(5));
    btn_a = 1; cyc("ready_ign_a", zz(5));
    btn_b = 1; cyc("ready_bb", zz(5));
    tick = 1; cyc("runa_t1", ra(5, 1));
    cyc("runa_t0", ra(5, 0));
    tick = 1; cyc("runa_t2", ra(5, 1));
    tick = 1; cyc("runa_t3", ra(5, 1));
    btn_a = 1; btn_b = 1; tick = 1; cyc("handover", ra(5, 1));
    tick = 1; cyc("runb_t", rb(5, 1));
    btn_a = 1; tick = 1; cyc("runb_ign_a", rb(5, 1));
    cyc("runb_stay", rb(5, 0));
    start_pause = 1; tick = 1; cyc("sp_cyc", rb(5, 1));
    tick = 1; cyc("pause_t", ex(0, 5, 0, 0, 0, 1, 1, 0, 0));
    btn_b = 1; cyc("pause_ign_b", ex(0, 5, 0, 0, 0, 1, 1, 0, 0));
    start_pause = 1; cyc("resume_cyc", ex(0, 5, 0, 0, 0, 1, 1, 0, 0));
    tick = 1; cyc("resumed", rb(5, 1));
    min_b = 0; sec_b = 0; cyc("zero_b", rb(5, 0));
    tick = 1; cyc("flag_b", ex(0, 5, 0, 0, 0, 1, 0, 0, 1));
    start_pause = 1; btn_b = 1; tick = 1; cyc("flag_b_hold", ex(0, 5, 0, 0, 0, 1, 0, 0, 1));
    min_b = 5;
    time_cfg = 0; new_game = 1; cyc("ng_flag_b", ex(0, 5, 0, 0, 0, 1, 0, 0, 1));
    cyc("load_clamp", ex(1, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc("ready2", zz(1));
    start_pause = 1; cyc("ready_sp", zz(1));
    min_a = 0; sec_a = 0; start_pause = 1; btn_a = 1; tick = 1; cyc("fa_cyc", ra(1, 1));
    tick = 1; cyc("flag_a", ex(0, 1, 0, 0, 1, 0, 0, 1, 0));
    min_a = 5;
    time_cfg = 7; new_game = 1; cyc("ng_flag_a", ex(0, 1, 0, 0, 1, 0, 0, 1, 0));
    cyc("load7", ex(1, 7, 0, 0, 0, 0, 0, 0, 0));
    cyc("ready7", zz(7));
    btn_b = 1; cyc("ready7_bb", zz(7));
    min_a = 0; sec_a = 0; new_game = 1; cyc("ng_vs_flag", ra(7, 0));
    min_a = 5; cyc("ng_wins", ex(1, 7, 0, 0, 0, 0, 0, 0, 0));
    cyc("ready7b", zz(7));
    btn_b = 1; cyc("ready7b_bb", zz(7));
`ifdef MOVE_COUNT_EN
    cycm("moves_clr", ra(7, 0), 1, 0);
    for (int i = 0; i < 3; i++) begin
      btn_a = 1; cyc("mv_a", ra(7, 0));
      btn_b = 1; cyc("mv_b", rb(7, 0));
    end
    cycm("moves3", ra(7, 0), 1, 3);
    for (int i = 0; i < 260; i++) begin
      btn_a = 1; cyc("mv_a", ra(7, 0));
      btn_b = 1; cyc("mv_b", rb(7, 0));
    end
    cycm("moves_sat", ra(7, 0), 1, 255);
`endif
    tick = 1; cyc("pre_rst", ra(7, 1));
    rst = 1; tick = 1; cyc("rst_async", zz(1));
    rst = 0; tick = 1; cyc("post_rst", zz(1));
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
